serial_program_loader: RTL and testbench



---
 rtl/serial_program_loader.sv | 165 ++++++++++++++++
 tb/tb_serial_program_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_program_loader.sv
// UART-driven program loader for blocpu_core: decodes load/run/stop commands,
// writes instructions into the core and answers load frames with ACK/NAK.
module serial_program_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 16777215,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        core_reset,
  output logic        core_running,
  output logic [11:0] instr,
  output logic [15:0] instr_addr,
  output logic        instr_write,
  output logic        busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, INSTR_HI, INSTR_LO
  } state_t;

  state_t        state, state_next;
  logic [15:0]   addr;
  logic [15:0]   cnt;
  logic [3:0]    nibble;
  logic [TW-1:0] timer;
  logic          pending;
  logic [7:0]    pend_byte;

  logic timeout, queue_ack, queue_nak, do_write, cmd_halt, cmd_run;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    queue_ack  = 1'b0;
    queue_nak  = 1'b0;
    do_write   = 1'b0;
    cmd_halt   = 1'b0;
    cmd_run    = 1'b0;
    // An arriving byte always takes precedence over an expiring timer.
    timeout    = (state != IDLE) && !rx_valid && (timer == TW'(TIMEOUT_CYCLES - 1));
    if (rx_valid) begin
      unique case (state)
        IDLE: begin
          unique case (rx_data)
            8'h4C: begin
              state_next = ADDR_HI;
              cmd_halt   = 1'b1;
            end
            8'h52:   cmd_run  = 1'b1;
            8'h53:   cmd_halt = 1'b1;
            default: ;
          endcase
        end
        ADDR_HI: state_next = ADDR_LO;
        ADDR_LO: state_next = CNT_HI;
        CNT_HI:  state_next = CNT_LO;
        CNT_LO: begin
          if ({cnt[15:8], rx_data} == 16'd0) begin
            state_next = IDLE;
            queue_ack  = 1'b1;
          end else begin
            state_next = INSTR_HI;
          end
        end
        INSTR_HI: begin
          if (rx_data[7:4] != 4'd0) begin
            state_next = IDLE;
            queue_nak  = 1'b1;
          end else begin
            state_next = INSTR_LO;
          end
        end
        INSTR_LO: begin
          do_write = 1'b1;
          if (cnt == 16'd1) begin
            state_next = IDLE;
            queue_ack  = 1'b1;
          end else begin
            state_next = INSTR_HI;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout) begin
      state_next = IDLE;
      queue_nak  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      core_reset   <= 1'b1;
      core_running <= 1'b0;
      instr        <= '0;
      instr_addr   <= '0;
      instr_write  <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      busy         <= 1'b0;
      addr         <= '0;
      cnt          <= '0;
      nibble       <= '0;
      timer        <= '0;
      pending      <= 1'b0;
      pend_byte    <= '0;
    end else begin
      instr_write <= do_write;
      busy        <= (state_next != IDLE);

      if (rx_valid || state_next == IDLE) timer <= '0;
      else                                timer <= timer + TW'(1);

      if (rx_valid) begin
        unique case (state)
          ADDR_HI:  addr[15:8] <= rx_data;
          ADDR_LO:  addr[7:0]  <= rx_data;
          CNT_HI:   cnt[15:8]  <= rx_data;
          CNT_LO:   cnt[7:0]   <= rx_data;
          INSTR_HI: nibble     <= rx_data[3:0];
          default:  ;
        endcase
      end

      if (do_write) begin
        instr      <= {nibble, rx_data};
        instr_addr <= addr;
        addr       <= addr + 16'd1;
        cnt        <= cnt - 16'd1;
      end

      if (cmd_halt) begin
        core_running <= 1'b0;
        core_reset   <= 1'b1;
      end else if (cmd_run) begin
        core_running <= 1'b1;
        core_reset   <= 1'b0;
      end

      // Single-entry response slot: a newer ACK/NAK replaces an unsent one.
      tx_start <= 1'b0;
      if (pending && !tx_busy) begin
        tx_start <= 1'b1;
        tx_data  <= pend_byte;
        pending  <= 1'b0;
      end
      if (queue_ack || queue_nak) begin
        pending   <= 1'b1;
        pend_byte <= queue_nak ? NAK_BYTE : ACK_BYTE;
      end
    end
  end

endmodule

// File: tb/tb_serial_program_loader.sv
// Bench for serial_program_loader: directed command scenarios plus randomized
// load frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_serial_program_loader;

  localparam int unsigned TMO = 100;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        core_reset;
  logic        core_running;
  logic [11:0] instr;
  logic [15:0] instr_addr;
  logic        instr_write;
  logic        busy;

  serial_program_loader #(
    .TIMEOUT_CYCLES(TMO),
    .ACK_BYTE(8'h06),
    .NAK_BYTE(8'h15)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .core_reset(core_reset), .core_running(core_running), .instr(instr),
    .instr_addr(instr_addr), .instr_write(instr_write), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed events, sampled just after each active edge.
  int          wr_cyc[$];
  logic [15:0] wr_addr[$];
  logic [11:0] wr_ins[$];
  int          tx_cyc[$];
  logic [7:0]  tx_byte[$];
  int          sent_cyc[$];

  always @(posedge clk) begin
    #1;
    if (instr_write === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(instr_addr);
      wr_ins.push_back(instr);
    end
    if (tx_start === 1'b1) begin
      tx_cyc.push_back(cyc);
      tx_byte.push_back(tx_data);
    end
  end

  // Reference model results for one load frame.
  logic [15:0] exp_addr[$];
  logic [11:0] exp_ins[$];
  int          exp_idx[$];
  int          exp_resp;

  function automatic void model_load(input bq_t fr);
    int unsigned base, n;
    exp_addr.delete(); exp_ins.delete(); exp_idx.delete();
    base = int'(fr[1]) * 256 + int'(fr[2]);
    n    = int'(fr[3]) * 256 + int'(fr[4]);
    exp_resp = 8'h06;
    for (int unsigned i = 0; i < n; i++) begin
      int p;
      p = 5 + 2 * int'(i);
      if (fr[p] > 8'h0F) begin
        exp_resp = 8'h15;
        return;
      end
      exp_addr.push_back(16'((base + i) % 65536));
      exp_ins.push_back(12'(int'(fr[p]) * 256 + int'(fr[p+1])));
      exp_idx.push_back(p + 1);
    end
  endfunction

  task automatic clear_mon();
    wr_cyc.delete(); wr_addr.delete(); wr_ins.delete();
    tx_cyc.delete(); tx_byte.delete();
  endtask

  // Called at a negedge; returns at a negedge, gap idle cycles later.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_valid = 1'b1;
    sent_cyc.push_back(cyc);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input bq_t fr, input int gapmax);
    sent_cyc.delete();
    foreach (fr[i]) send_byte(fr[i], int'($urandom_range(gapmax, 0)));
  endtask

  task automatic wait_tx(input int limit);
    for (int i = 0; i < limit && tx_byte.size() == 0; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL reset_core_reset: got %b want 1", core_reset); end
    n_cmp++; if (core_running !== 1'b0) begin n_fail++; $display("FAIL reset_core_running: got %b want 0", core_running); end
    n_cmp++; if (instr_write !== 1'b0) begin n_fail++; $display("FAIL reset_instr_write: got %b want 0", instr_write); end
    n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({instr, instr_addr, tx_data} !== 36'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h/%h want 0", instr, instr_addr, tx_data); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_directed();
    logic [7:0]  frames[2][9] = '{'{8'h4C, 8'h00, 8'h00, 8'h00, 8'h02, 8'h0E, 8'h02, 8'h0F, 8'h0D},
                                  '{8'h4C, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h01, 8'h23, 8'h04, 8'h56}};
    logic [15:0] ea[2][2] = '{'{16'h0000, 16'h0001}, '{16'hFFFF, 16'h0000}};
    logic [11:0] ei[2][2] = '{'{12'hE02, 12'hF0D}, '{12'h123, 12'h456}};
    for (int t = 0; t < 2; t++) begin
      bq_t fr;
      for (int k = 0; k < 9; k++) fr.push_back(frames[t][k]);
      clear_mon();
      send_frame(fr, 0);
      wait_tx(10);
      repeat (3) @(negedge clk);
      n_cmp++; if (wr_cyc.size() != 2) begin n_fail++; $display("FAIL load%0d_write_count: got %0d want 2", t, wr_cyc.size()); end
      for (int i = 0; i < 2 && i < wr_cyc.size(); i++) begin
        n_cmp++; if (wr_addr[i] !== ea[t][i]) begin n_fail++; $display("FAIL load%0d_addr%0d: got %h want %h", t, i, wr_addr[i], ea[t][i]); end
        n_cmp++; if (wr_ins[i] !== ei[t][i]) begin n_fail++; $display("FAIL load%0d_instr%0d: got %h want %h", t, i, wr_ins[i], ei[t][i]); end
        n_cmp++; if (wr_cyc[i] != sent_cyc[6 + 2*i] + 1) begin n_fail++; $display("FAIL load%0d_latency%0d: got cycle %0d want %0d", t, i, wr_cyc[i], sent_cyc[6 + 2*i] + 1); end
      end
      n_cmp++; if (tx_byte.size() != 1 || tx_byte[0] !== 8'h06) begin n_fail++; $display("FAIL load%0d_ack: got %0d bytes first %h want 1 byte 06", t, tx_byte.size(), (tx_byte.size() > 0) ? tx_byte[0] : 8'hxx); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL load%0d_busy: got %b want 0", t, busy); end
      n_cmp++; if (instr !== ei[t][1] || instr_addr !== ea[t][1]) begin n_fail++; $display("FAIL load%0d_hold: got %h@%h want %h@%h", t, instr, instr_addr, ei[t][1], ea[t][1]); end
    end
  endtask

  task automatic test_bad_nibble_run();
    clear_mon();
    send_frame('{8'h4C, 8'h00, 8'h10, 8'h00, 8'h01, 8'hF1}, 0);
    wait_tx(10);
    repeat (3) @(negedge clk);
    n_cmp++; if (wr_cyc.size() != 0) begin n_fail++; $display("FAIL bad_nibble_writes: got %0d want 0", wr_cyc.size()); end
    n_cmp++; if (tx_byte.size() != 1 || tx_byte[0] !== 8'h15) begin n_fail++; $display("FAIL bad_nibble_nak: got %0d bytes first %h want 1 byte 15", tx_byte.size(), (tx_byte.size() > 0) ? tx_byte[0] : 8'hxx); end
    n_cmp++; if (busy !== 1'b0 || core_reset !== 1'b1) begin n_fail++; $display("FAIL bad_nibble_idle: got busy %b core_reset %b want 0 1", busy, core_reset); end
    send_byte(8'h52, 0);
    n_cmp++; if (core_running !== 1'b1 || core_reset !== 1'b0) begin n_fail++; $display("FAIL run_cmd: got running %b reset %b want 1 0", core_running, core_reset); end
  endtask

  task automatic test_timeout();
    int n, m;
    clear_mon();
    send_frame('{8'h4C, 8'h00, 8'h00, 8'h00, 8'h01}, 0);
    n = cyc;
    repeat (TMO - 2) @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || tx_byte.size() != 0) begin n_fail++; $display("FAIL timeout_early: got busy %b tx %0d want 1 0", busy, tx_byte.size()); end
    wait_tx(6);
    n_cmp++; if (tx_byte.size() != 1 || tx_byte[0] !== 8'h15) begin n_fail++; $display("FAIL timeout_nak: got %0d bytes want 1 byte 15", tx_byte.size()); end
    else begin
      n_cmp++; if (tx_cyc[0] < n + int'(TMO) || tx_cyc[0] > n + int'(TMO) + 2) begin n_fail++; $display("FAIL timeout_when: got cycle %0d want %0d..%0d", tx_cyc[0], n + int'(TMO), n + int'(TMO) + 2); end
    end
    n_cmp++; if (busy !== 1'b0 || wr_cyc.size() != 0) begin n_fail++; $display("FAIL timeout_idle: got busy %b writes %0d want 0 0", busy, wr_cyc.size()); end

    clear_mon();
    send_frame('{8'h4C, 8'h00, 8'h20, 8'h00, 8'h01}, 0);
    repeat (TMO - 2) @(negedge clk);
    send_byte(8'h01, 0);
    m = cyc;
    repeat (TMO - 1) @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || tx_byte.size() != 0) begin n_fail++; $display("FAIL timeout_restart: got busy %b tx %0d at cycle %0d want 1 0", busy, tx_byte.size(), cyc - m); end
    send_byte(8'hAB, 0);
    wait_tx(6);
    repeat (3) @(negedge clk);
    n_cmp++; if (wr_cyc.size() != 1 || wr_ins[0] !== 12'h1AB || wr_addr[0] !== 16'h0020) begin n_fail++; $display("FAIL timeout_collide_write: got %0d writes want 1 of 1AB@0020", wr_cyc.size()); end
    n_cmp++; if (tx_byte.size() != 1 || tx_byte[0] !== 8'h06) begin n_fail++; $display("FAIL timeout_collide_ack: got %0d bytes want 1 byte 06", tx_byte.size()); end
  endtask

  task automatic test_busy_ack();
    send_byte(8'h52, 0);
    n_cmp++; if (core_running !== 1'b1) begin n_fail++; $display("FAIL busy_pre_run: got %b want 1", core_running); end
    clear_mon();
    tx_busy = 1'b1;
    send_byte(8'h4C, 0);
    n_cmp++; if (core_running !== 1'b0 || core_reset !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL load_halts_core: got running %b reset %b busy %b want 0 1 1", core_running, core_reset, busy); end
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    repeat (10) @(negedge clk);
    n_cmp++; if (tx_byte.size() != 0) begin n_fail++; $display("FAIL ack_held: got %0d bytes want 0 while tx_busy", tx_byte.size()); end
    tx_busy = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (tx_byte.size() != 1 || tx_byte[0] !== 8'h06) begin n_fail++; $display("FAIL ack_released: got %0d bytes want 1 byte 06", tx_byte.size()); end
    send_byte(8'h53, 0);
    n_cmp++; if (core_reset !== 1'b1 || core_running !== 1'b0) begin n_fail++; $display("FAIL stop_cmd: got reset %b running %b want 1 0", core_reset, core_running); end

    clear_mon();
    tx_busy = 1'b1;
    send_frame('{8'h4C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h4C, 8'h00, 8'h00, 8'h00, 8'h01, 8'hF0}, 1);
    repeat (5) @(negedge clk);
    tx_busy = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (tx_byte.size() != 1 || tx_byte[0] !== 8'h15) begin n_fail++; $display("FAIL overwrite: got %0d bytes first %h want 1 byte 15", tx_byte.size(), (tx_byte.size() > 0) ? tx_byte[0] : 8'hxx); end
  endtask

  task automatic test_idle_ignore();
    clear_mon();
    send_byte(8'h52, 0);
    send_frame('{8'h41, 8'h00, 8'hFF, 8'h06}, 1);
    repeat (5) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || tx_byte.size() != 0 || wr_cyc.size() != 0) begin n_fail++; $display("FAIL idle_ignore: got busy %b tx %0d writes %0d want 0 0 0", busy, tx_byte.size(), wr_cyc.size()); end
    n_cmp++; if (core_running !== 1'b1 || core_reset !== 1'b0) begin n_fail++; $display("FAIL idle_ignore_core: got running %b reset %b want 1 0", core_running, core_reset); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    send_frame('{8'h4C, 8'h00, 8'h00, 8'h00}, 0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
    repeat (TMO + 20) @(negedge clk);
    n_cmp++; if (tx_byte.size() != 0 || wr_cyc.size() != 0) begin n_fail++; $display("FAIL midreset_silent: got tx %0d writes %0d want 0 0", tx_byte.size(), wr_cyc.size()); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 16; f++) begin
      bq_t fr;
      logic [15:0] a;
      int n, bad;
      logic [7:0] specials[4] = '{8'h4C, 8'h52, 8'h53, 8'h00};
      a = 16'($urandom);
      if (f % 4 == 0) a = 16'hFFFF - 16'($urandom_range(2, 0));
      n = (f == 5) ? 0 : int'($urandom_range(5, 1));
      bad = (n > 0 && $urandom_range(3, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
      fr = '{8'h4C, a[15:8], a[7:0], 8'(n >> 8), 8'(n)};
      for (int j = 0; j < n; j++) begin
        if (j == bad) begin
          fr.push_back({4'($urandom_range(15, 1)), 4'($urandom)});
          break;
        end
        fr.push_back({4'h0, 4'($urandom)});
        fr.push_back(($urandom_range(2, 0) == 0) ? specials[$urandom_range(3, 0)] : 8'($urandom));
      end
      if (f % 3 == 1) begin
        send_byte(8'h52, int'($urandom_range(2, 0)));
        n_cmp++; if (core_running !== 1'b1) begin n_fail++; $display("FAIL rand%0d_run: got %b want 1", f, core_running); end
      end
      clear_mon();
      model_load(fr);
      send_frame(fr, 3);
      wait_tx(20);
      repeat (3) @(negedge clk);
      n_cmp++; if (wr_cyc.size() != exp_addr.size()) begin n_fail++; $display("FAIL rand%0d_write_count: got %0d want %0d", f, wr_cyc.size(), exp_addr.size()); end
      for (int i = 0; i < wr_cyc.size() && i < exp_addr.size(); i++) begin
        n_cmp++;
        if (wr_addr[i] !== exp_addr[i] || wr_ins[i] !== exp_ins[i] || wr_cyc[i] != sent_cyc[exp_idx[i]] + 1) begin
          n_fail++;
          $display("FAIL rand%0d_write%0d: got %h@%h cyc %0d want %h@%h cyc %0d", f, i, wr_ins[i], wr_addr[i], wr_cyc[i], exp_ins[i], exp_addr[i], sent_cyc[exp_idx[i]] + 1);
        end
      end
      n_cmp++; if (tx_byte.size() != 1 || int'(tx_byte[0]) != exp_resp) begin n_fail++; $display("FAIL rand%0d_resp: got %0d bytes first %h want 1 byte %h", f, tx_byte.size(), (tx_byte.size() > 0) ? tx_byte[0] : 8'hxx, exp_resp); end
      n_cmp++; if (busy !== 1'b0 || core_running !== 1'b0 || core_reset !== 1'b1) begin n_fail++; $display("FAIL rand%0d_end: got busy %b running %b reset %b want 0 0 1", f, busy, core_running, core_reset); end
    end
  endtask

  initial begin
    test_reset();
    test_load_directed();
    test_bad_nibble_run();
    test_timeout();
    test_busy_ack();
    test_idle_ignore();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
